sprite_bank_mapper: RTL and testbench

Parametrised sprite tile-code bank mapper for the Taito F2 sprite path.
- CPU-programmed bank registers extend short sprite codes into wide ROM codes.
- Adds optional shadow (double-buffered) bank registers, committed on a frame strobe.
- Serves NUM_CH independent lookup channels, each with registered output and a valid flag.
- Sits between the sprite engine(s) and ROM address generation; bank state is save-stated over ssbus.

---
 rtl/sprite_bank_pkg.sv | 30 +++
 rtl/ssbus_if.sv | 27 ++
 rtl/sprite_bank_lookup.sv | 51 +++++
 rtl/sprite_bank_mapper.sv | 130 +++++++++++++
 tb/tb_sprite_bank_mapper.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_bank_pkg.sv
// rtl/sprite_bank_pkg.sv - shared constants and helpers for the sprite bank mapper
//
// Purpose: bank-select width helper, CPU register address offsets and the
// save-state register layout shared by the top and the lookup channels.
package sprite_bank_pkg;

  // Number of code MSBs that select a bank register.
  function automatic int sel_width(input int num_banks);
    return $clog2(num_banks);
  endfunction

  // The control register sits directly above the bank registers.
  localparam int CTRL_ADDR_OFS = 0;

  // Save-state layout: active banks, then pending banks, then shadow_en.
  localparam int SS_ACTIVE_OFS = 0;

  function automatic int ss_pending_base(input int num_banks);
    return num_banks;
  endfunction

  function automatic int ss_shadow_addr(input int num_banks);
    return 2 * num_banks;
  endfunction

  function automatic int ss_reg_count(input int num_banks);
    return 2 * num_banks + 1;
  endfunction

endpackage

// File: rtl/ssbus_if.sv
// rtl/ssbus_if.sv - save-state bus connecting a state manager to a block
//
// Purpose: the master selects a block by index and reads or writes one
// 64-bit register per access; the slave acknowledges combinationally and
// advertises its index, register count and layout version.
interface ssbus_if;
  logic [7:0]  sel_idx;
  logic [23:0] addr;
  logic [63:0] wdata;
  logic        wr;
  logic        rd;
  logic        ack;
  logic [63:0] rdata;
  logic [7:0]  setup_idx;
  logic [23:0] setup_count;
  logic [7:0]  setup_version;

  modport slave (
    input  sel_idx, addr, wdata, wr, rd,
    output ack, rdata, setup_idx, setup_count, setup_version
  );

  modport master (
    output sel_idx, addr, wdata, wr, rd,
    input  ack, rdata, setup_idx, setup_count, setup_version
  );
endinterface

// File: rtl/sprite_bank_lookup.sv
// rtl/sprite_bank_lookup.sv - one registered sprite code lookup channel
//
// Purpose: splits a short code into bank select and low bits, replaces the
// select with the addressed active bank register, registers the result.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req, i_code  : lookup request and original short code
//   i_active       : all active bank registers, bank k at [k*BANK_W +: BANK_W]
//   o_code, o_valid: mapped code and its valid flag, one cycle after i_req
module sprite_bank_lookup
  import sprite_bank_pkg::*;
#(
  parameter int NUM_BANKS  = 8,
  parameter int CODE_IN_W  = 14,
  parameter int BANK_W     = 8,
  parameter int CODE_OUT_W = 20
)(
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_req,
  input  logic [CODE_IN_W-1:0]        i_code,
  input  logic [NUM_BANKS*BANK_W-1:0] i_active,
  output logic [CODE_OUT_W-1:0]       o_code,
  output logic                        o_valid
);

  localparam int SEL_W = sel_width(NUM_BANKS);
  localparam int LOW_W = CODE_IN_W - SEL_W;

  logic [SEL_W-1:0]      w_sel;
  logic [LOW_W-1:0]      w_low;
  logic [BANK_W-1:0]     w_bank;
  logic [CODE_OUT_W-1:0] w_mapped;

  assign w_sel  = i_code[CODE_IN_W-1 -: SEL_W];
  assign w_low  = i_code[LOW_W-1:0];
  assign w_bank = i_active[w_sel*BANK_W +: BANK_W];
  // Size cast zero-extends or drops MSBs to fit the ROM code width.
  assign w_mapped = CODE_OUT_W'({w_bank, w_low});

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_code  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_req;
      if (i_req) o_code <= w_mapped;
    end
  end

endmodule

// File: rtl/sprite_bank_mapper.sv
// rtl/sprite_bank_mapper.sv - banked sprite code mapper with shadow registers
//
// Purpose: CPU-programmed bank registers widen sprite codes for NUM_CH
// lookup channels; optional shadow registers commit on the frame latch.
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_cpu_din/i_cs/i_cpu_addr/
//   i_cpu_rw/i_cpu_ds_n            : CPU write port (no read path)
//   i_latch                        : frame commit strobe
//   i_code_req, i_code_in          : per-channel lookup requests
//   o_code_out, o_code_valid       : per-channel mapped codes and valid
//   ssbus                          : save-state access to all registers
module sprite_bank_mapper
  import sprite_bank_pkg::*;
#(
  parameter int NUM_BANKS  = 8,
  parameter int CODE_IN_W  = 14,
  parameter int BANK_W     = 8,
  parameter int CODE_OUT_W = 20,
  parameter int NUM_CH     = 2,
  parameter int SS_IDX     = -1
)(
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [7:0]                     i_cpu_din,
  input  logic                           i_cs,
  input  logic [sel_width(NUM_BANKS):0]  i_cpu_addr,
  input  logic                           i_cpu_rw,
  input  logic                           i_cpu_ds_n,
  input  logic                           i_latch,
  input  logic [NUM_CH-1:0]              i_code_req,
  input  logic [NUM_CH*CODE_IN_W-1:0]    i_code_in,
  output logic [NUM_CH*CODE_OUT_W-1:0]   o_code_out,
  output logic [NUM_CH-1:0]              o_code_valid,
  ssbus_if.slave                         ssbus
);

  localparam int SEL_W     = sel_width(NUM_BANKS);
  localparam int ADDR_W    = SEL_W + 1;
  localparam int CTRL_ADDR = NUM_BANKS + CTRL_ADDR_OFS;
  localparam int SS_PEND   = ss_pending_base(NUM_BANKS);
  localparam int SS_SHADOW = ss_shadow_addr(NUM_BANKS);

  logic [BANK_W-1:0]           r_active  [NUM_BANKS];
  logic [BANK_W-1:0]           r_pending [NUM_BANKS];
  logic                        r_shadow_en;

  logic                        w_cpu_we;
  logic                        w_ss_we;
  logic                        w_ss_re;
  logic [BANK_W-1:0]           w_cpu_data;
  logic [BANK_W-1:0]           w_ss_data;
  logic [BANK_W-1:0]           w_ss_value;
  logic [NUM_BANKS*BANK_W-1:0] w_active_flat;

  assign w_cpu_we   = i_cs & ~i_cpu_rw & ~i_cpu_ds_n;
  assign w_cpu_data = i_cpu_din[BANK_W-1:0];
  assign w_ss_we    = (ssbus.sel_idx == SS_IDX[7:0]) & ssbus.wr;
  assign w_ss_re    = (ssbus.sel_idx == SS_IDX[7:0]) & ssbus.rd;
  assign w_ss_data  = ssbus.wdata[BANK_W-1:0];

  // Save-state writes take priority over CPU writes and the frame latch.
  // The latch copies pending as it was before any same-cycle CPU write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        r_active[k]  <= '0;
        r_pending[k] <= '0;
      end
      r_shadow_en <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (w_ss_we && ssbus.addr == 24'(SS_ACTIVE_OFS + k))
          r_active[k] <= w_ss_data;
        else if (w_cpu_we && i_cpu_addr == ADDR_W'(k) && !r_shadow_en)
          r_active[k] <= w_cpu_data;
        else if (i_latch && r_shadow_en)
          r_active[k] <= r_pending[k];

        if (w_ss_we && ssbus.addr == 24'(SS_PEND + k))
          r_pending[k] <= w_ss_data;
        else if (w_cpu_we && i_cpu_addr == ADDR_W'(k))
          r_pending[k] <= w_cpu_data;
      end
      if (w_ss_we && ssbus.addr == 24'(SS_SHADOW))
        r_shadow_en <= ssbus.wdata[0];
      else if (w_cpu_we && i_cpu_addr == ADDR_W'(CTRL_ADDR))
        r_shadow_en <= i_cpu_din[0];
    end
  end

  always_comb begin
    w_ss_value = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (ssbus.addr == 24'(SS_ACTIVE_OFS + k)) w_ss_value = r_active[k];
      if (ssbus.addr == 24'(SS_PEND + k))       w_ss_value = r_pending[k];
    end
    if (ssbus.addr == 24'(SS_SHADOW)) w_ss_value = BANK_W'(r_shadow_en);
  end

  assign ssbus.ack           = w_ss_we | w_ss_re;
  assign ssbus.rdata         = w_ss_re ? 64'(w_ss_value) : 64'd0;
  assign ssbus.setup_idx     = SS_IDX[7:0];
  assign ssbus.setup_count   = 24'(ss_reg_count(NUM_BANKS));
  assign ssbus.setup_version = 8'd0;

  always_comb begin
    w_active_flat = '0;
    for (int k = 0; k < NUM_BANKS; k++)
      w_active_flat[k*BANK_W +: BANK_W] = r_active[k];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sprite_bank_lookup #(
      .NUM_BANKS  (NUM_BANKS),
      .CODE_IN_W  (CODE_IN_W),
      .BANK_W     (BANK_W),
      .CODE_OUT_W (CODE_OUT_W)
    ) u_lookup (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_req    (i_code_req[c]),
      .i_code   (i_code_in[c*CODE_IN_W +: CODE_IN_W]),
      .i_active (w_active_flat),
      .o_code   (o_code_out[c*CODE_OUT_W +: CODE_OUT_W]),
      .o_valid  (o_code_valid[c])
    );
  end

endmodule

// File: tb/tb_sprite_bank_mapper.sv
// tb/tb_sprite_bank_mapper.sv - self-checking bench for sprite_bank_mapper
module tb_sprite_bank_mapper;
  localparam int NB  = 8;
  localparam int CIW = 14;
  localparam int COW = 20;
  localparam int NCH = 2;
  localparam int AW  = 4;
  localparam logic [7:0] SS = 8'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [7:0]       cpu_din;
  logic             cs, cpu_rw, cpu_ds_n, latch;
  logic [AW-1:0]    cpu_addr;
  logic [NCH-1:0]   code_req;
  logic [NCH*CIW-1:0] code_in;
  logic [NCH*COW-1:0] code_out;
  logic [NCH-1:0]   code_valid;
  ssbus_if ss();

  sprite_bank_mapper #(
    .NUM_BANKS(NB), .CODE_IN_W(CIW), .BANK_W(8), .CODE_OUT_W(COW),
    .NUM_CH(NCH), .SS_IDX(3)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_cpu_din(cpu_din), .i_cs(cs),
    .i_cpu_addr(cpu_addr), .i_cpu_rw(cpu_rw), .i_cpu_ds_n(cpu_ds_n),
    .i_latch(latch), .i_code_req(code_req), .i_code_in(code_in),
    .o_code_out(code_out), .o_code_valid(code_valid), .ssbus(ss)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]     m_act [NB];
  logic [7:0]     m_pend [NB];
  logic           m_sh;
  logic [NCH-1:0] m_valid;
  logic [COW-1:0] m_last [NCH];
  logic [COW-1:0] q0[$];
  logic [COW-1:0] q1[$];

  function automatic logic [COW-1:0] model_code(input logic [CIW-1:0] c);
    int sel;
    logic [31:0] v;
    sel = int'(c) / 2048;
    v = (32'(m_act[sel]) * 32'd2048) + 32'(c % 14'd2048);
    return v[COW-1:0];
  endfunction

  function automatic logic [63:0] m_reg(input int a);
    if (a < NB) return 64'(m_act[a]);
    if (a < 2*NB) return 64'(m_pend[a-NB]);
    if (a == 2*NB) return 64'(m_sh);
    return 64'd0;
  endfunction

  task automatic idle_inputs();
    cs = 0; cpu_rw = 1; cpu_ds_n = 1; latch = 0; code_req = '0;
    ss.wr = 0; ss.rd = 0; ss.sel_idx = SS; ss.addr = '0; ss.wdata = '0;
  endtask

  // Advance one clock, updating the reference model from the driven inputs.
  task automatic tick();
    logic [7:0] op [NB];
    logic osh;
    op = m_pend;
    osh = m_sh;
    if (!reset) begin
      if (code_req[0]) q0.push_back(model_code(code_in[0 +: CIW]));
      if (code_req[1]) q1.push_back(model_code(code_in[CIW +: CIW]));
    end
    if (reset) begin
      for (int k = 0; k < NB; k++) begin m_act[k] = 0; m_pend[k] = 0; end
      m_sh = 0; m_valid = 0;
      for (int c = 0; c < NCH; c++) m_last[c] = 0;
    end else begin
      m_valid = code_req;
      if (latch && osh) for (int k = 0; k < NB; k++) m_act[k] = op[k];
      if (cs && !cpu_rw && !cpu_ds_n) begin
        if (cpu_addr < NB) begin
          m_pend[cpu_addr] = cpu_din;
          if (!osh) m_act[cpu_addr] = cpu_din;
        end else if (cpu_addr == NB) m_sh = cpu_din[0];
      end
      if (ss.wr && ss.sel_idx == SS) begin
        if (ss.addr < NB) m_act[ss.addr] = ss.wdata[7:0];
        else if (ss.addr < 2*NB) m_pend[ss.addr-NB] = ss.wdata[7:0];
        else if (ss.addr == 2*NB) m_sh = ss.wdata[0];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
    cs = 1; cpu_rw = 0; cpu_ds_n = 0; cpu_addr = a; cpu_din = d;
    tick();
    cs = 0; cpu_rw = 1; cpu_ds_n = 1;
  endtask

  task automatic ss_read(input int a, output logic [63:0] d);
    ss.addr = 24'(a); ss.rd = 1; #1;
    d = ss.rdata;
    ss.rd = 0; #1;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    reset = 1; code_req = 2'b11; code_in = {14'h3FFF, 14'h3FFF};
    tick(); tick();
    reset = 0; code_req = 0;
    checks++; if (code_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", code_valid); end
    checks++; if (code_out !== '0) begin failures++; $display("FAIL reset_code got=%h exp=0", code_out); end
    for (int a = 0; a <= 2*NB; a++) begin
      ss_read(a, d);
      checks++; if (d !== 64'd0) begin failures++; $display("FAIL reset_ss_reg%0d got=%h exp=0", a, d); end
    end
    checks++; if (ss.setup_count !== 24'd17) begin failures++; $display("FAIL setup_count got=%0d exp=17", ss.setup_count); end
  endtask

  task automatic test_direct_map();
    logic [COW-1:0] e;
    cpu_write(4'd5, 8'h3C);
    code_req = 2'b01; code_in[0 +: CIW] = 14'h2ABC;
    tick();
    code_req = 0;
    e = q0.pop_front(); m_last[0] = e;
    checks++; if (code_valid[0] !== 1'b1) begin failures++; $display("FAIL direct_valid got=%b exp=1", code_valid[0]); end
    checks++; if (code_out[0 +: COW] !== 20'h1E2BC || e !== 20'h1E2BC) begin failures++; $display("FAIL direct_code got=%h exp=1e2bc", code_out[0 +: COW]); end
    checks++; if (code_valid[1] !== 1'b0) begin failures++; $display("FAIL direct_ch1_idle got=%b exp=0", code_valid[1]); end
    tick();
    checks++; if (code_valid[0] !== 1'b0) begin failures++; $display("FAIL hold_valid got=%b exp=0", code_valid[0]); end
    checks++; if (code_out[0 +: COW] !== m_last[0]) begin failures++; $display("FAIL hold_code got=%h exp=%h", code_out[0 +: COW], m_last[0]); end
  endtask

  task automatic test_shadow_latch();
    logic [COW-1:0] e;
    cpu_write(4'd8, 8'h01);
    cpu_write(4'd2, 8'h11);
    code_req = 2'b01; code_in[0 +: CIW] = 14'h1000;
    tick(); code_req = 0;
    e = q0.pop_front();
    checks++; if (code_out[0 +: COW] !== 20'h00000 || e !== 20'h00000) begin failures++; $display("FAIL shadow_pre got=%h exp=00000", code_out[0 +: COW]); end
    latch = 1; tick(); latch = 0;
    code_req = 2'b01; tick(); code_req = 0;
    e = q0.pop_front();
    checks++; if (code_out[0 +: COW] !== 20'h08800 || e !== 20'h08800) begin failures++; $display("FAIL shadow_post got=%h exp=08800", code_out[0 +: COW]); end
  endtask

  task automatic test_latch_conflict();
    logic [63:0] d;
    latch = 1; cpu_write(4'd2, 8'h22); latch = 0;
    ss_read(2, d);
    checks++; if (d !== 64'h11 || m_reg(2) !== 64'h11) begin failures++; $display("FAIL conflict_active got=%h exp=11", d); end
    ss_read(NB + 2, d);
    checks++; if (d !== 64'h22) begin failures++; $display("FAIL conflict_pending got=%h exp=22", d); end
    latch = 1; tick(); latch = 0;
    ss_read(2, d);
    checks++; if (d !== 64'h22) begin failures++; $display("FAIL conflict_commit got=%h exp=22", d); end
  endtask

  task automatic test_ssbus();
    logic [63:0] d;
    cpu_write(4'd8, 8'h00);
    ss_read(2, d);
    checks++; if (d !== m_reg(2)) begin failures++; $display("FAIL shadow_off_keep got=%h exp=%h", d, m_reg(2)); end
    cs = 1; cpu_rw = 0; cpu_ds_n = 0; cpu_addr = 4'd3; cpu_din = 8'h01;
    ss.wr = 1; ss.addr = 24'd3; ss.wdata = 64'h7F; #1;
    checks++; if (ss.ack !== 1'b1) begin failures++; $display("FAIL ss_ack got=%b exp=1", ss.ack); end
    tick();
    cs = 0; cpu_rw = 1; cpu_ds_n = 1; ss.wr = 0;
    ss_read(3, d);
    checks++; if (d !== 64'h7F || m_reg(3) !== 64'h7F) begin failures++; $display("FAIL ss_wins got=%h exp=7f", d); end
    ss_read(NB + 3, d);
    checks++; if (d !== m_reg(NB + 3)) begin failures++; $display("FAIL ss_pending got=%h exp=%h", d, m_reg(NB + 3)); end
    ss.wr = 1; ss.addr = 24'(2*NB); ss.wdata = 64'h1; tick(); ss.wr = 0;
    ss_read(2*NB, d);
    checks++; if (d !== 64'h1) begin failures++; $display("FAIL ss_shadow got=%h exp=1", d); end
    ss.sel_idx = 8'd9; ss.wr = 1; ss.addr = 24'd4; ss.wdata = 64'hAA; tick(); ss.wr = 0; ss.sel_idx = SS;
    ss_read(4, d);
    checks++; if (d !== m_reg(4)) begin failures++; $display("FAIL ss_other_idx got=%h exp=%h", d, m_reg(4)); end
    cpu_write(4'd8, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [COW-1:0] e;
    for (int k = 0; k < NB; k++) cpu_write(AW'(k), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) begin
      code_req = 2'b11;
      code_in[0 +: CIW] = 14'($urandom);
      code_in[CIW +: CIW] = 14'($urandom);
      if (i == 8) begin
        cs = 1; cpu_rw = 0; cpu_ds_n = 0;
        cpu_addr = {1'b0, code_in[CIW-1 -: 3]}; cpu_din = 8'hE5;
      end
      tick();
      cs = 0; cpu_rw = 1; cpu_ds_n = 1;
      for (int c = 0; c < NCH; c++) begin
        checks++; if (code_valid[c] !== 1'b1) begin failures++; $display("FAIL b2b_valid ch%0d cyc%0d got=%b exp=1", c, i, code_valid[c]); end
        if ((c == 0 ? q0.size() : q1.size()) == 0) begin
          checks++; failures++; $display("FAIL b2b_queue ch%0d cyc%0d got=empty exp=entry", c, i);
        end else begin
          e = (c == 0) ? q0.pop_front() : q1.pop_front();
          checks++; if (code_out[c*COW +: COW] !== e) begin failures++; $display("FAIL b2b_code ch%0d cyc%0d got=%h exp=%h", c, i, code_out[c*COW +: COW], e); end
        end
      end
    end
    code_req = 0;
  endtask

  task automatic test_reset_midflight();
    logic [63:0] d;
    code_req = 2'b11; code_in = {14'h1234, 14'h2ABC}; tick();
    reset = 1; tick();
    reset = 0; code_req = 0;
    q0.delete(); q1.delete();
    checks++; if (code_valid !== 2'b00) begin failures++; $display("FAIL midreset_valid got=%b exp=00", code_valid); end
    checks++; if (code_out !== '0) begin failures++; $display("FAIL midreset_code got=%h exp=0", code_out); end
    for (int a = 0; a <= 2*NB; a++) begin
      ss_read(a, d);
      checks++; if (d !== 64'd0) begin failures++; $display("FAIL midreset_ss_reg%0d got=%h exp=0", a, d); end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1; cpu_addr = '0; cpu_din = '0; code_in = '0;
    test_reset();
    test_direct_map();
    test_shadow_latch();
    test_latch_conflict();
    test_ssbus();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
